scr1_pipe_mprf_wb_arb: RTL and testbench

- Write-back arbiter and load scoreboard in front of the single-write-port MPRF.
- Shares the MPRF write port between three sources: the EXU result, the LSU load return (with a one-entry skid buffer) and the debug-controller register write.
- Tracks the one outstanding load destination and flags read-after-load hazards to the EXU.
- Drives the MPRF write request, address and data.

---
 rtl/scr1_mprf_wb_pkg.sv | 33 +++
 rtl/scr1_pipe_wb_skid.sv | 34 +++
 rtl/scr1_pipe_mprf_wb_arb.sv | 159 +++++++++++++++
 tb/tb_scr1_pipe_mprf_wb_arb.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scr1_mprf_wb_pkg.sv
// Shared types and defaults for the MPRF write-back arbiter and its LSU skid buffer.
package scr1_mprf_wb_pkg;

  localparam int SCR1_MPRF_ADDR_WIDTH = 5;
  localparam int SCR1_XLEN            = 32;
  localparam int SCR1_DBG_STARVE_MAX  = 8;

  typedef enum logic [2:0] {
    WB_NONE,
    WB_EXU,
    WB_BUF,
    WB_LSU,
    WB_DBG
  } type_scr1_wb_src_e;

  typedef enum logic {
    DBG_NORMAL,
    DBG_FORCE
  } type_scr1_dbg_fsm_e;

  typedef struct packed {
    logic                            vd;
    logic [SCR1_MPRF_ADDR_WIDTH-1:0] addr;
    logic [SCR1_XLEN-1:0]            data;
  } type_scr1_wb_req_s;

  // x0 is hardwired, so a zero source index never depends on an in-flight load
  function automatic logic rd_match(input logic [SCR1_MPRF_ADDR_WIDTH-1:0] rs,
                                    input logic [SCR1_MPRF_ADDR_WIDTH-1:0] rd);
    return (rs != '0) && (rs == rd);
  endfunction

endpackage

// File: rtl/scr1_pipe_wb_skid.sv
// One-entry skid buffer holding load data that lost write-port arbitration.
module scr1_pipe_wb_skid
  import scr1_mprf_wb_pkg::*;
#(
  parameter int ADDR_W = SCR1_MPRF_ADDR_WIDTH,
  parameter int XLEN   = SCR1_XLEN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic [XLEN-1:0]   push_data,
  input  logic              drain,
  output logic              buf_vld,
  output logic [ADDR_W-1:0] buf_addr,
  output logic [XLEN-1:0]   buf_data
);

  // push is only possible while empty, so push and drain never overlap
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_vld  <= 1'b0;
      buf_addr <= '0;
      buf_data <= '0;
    end else if (push) begin
      buf_vld  <= 1'b1;
      buf_addr <= push_addr;
      buf_data <= push_data;
    end else if (drain) begin
      buf_vld  <= 1'b0;
    end
  end

endmodule

// File: rtl/scr1_pipe_mprf_wb_arb.sv
// MPRF write-port arbiter (EXU / LSU skid / debug) with one-entry load scoreboard
// and a debug starvation guard that forces a debug write after repeated denials.
module scr1_pipe_mprf_wb_arb
  import scr1_mprf_wb_pkg::*;
#(
  parameter int ADDR_W         = SCR1_MPRF_ADDR_WIDTH,
  parameter int XLEN           = SCR1_XLEN,
  parameter int DBG_STARVE_MAX = SCR1_DBG_STARVE_MAX
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              exu_w_req,
  input  logic [ADDR_W-1:0] exu_rd_addr,
  input  logic [XLEN-1:0]   exu_rd_data,
  output logic              exu_stall,
  input  logic              lsu_w_vd,
  output logic              lsu_w_rdy,
  input  logic [ADDR_W-1:0] lsu_rd_addr,
  input  logic [XLEN-1:0]   lsu_rd_data,
  input  logic              dbg_w_req,
  output logic              dbg_w_ack,
  input  logic [ADDR_W-1:0] dbg_rd_addr,
  input  logic [XLEN-1:0]   dbg_rd_data,
  input  logic              ld_issue,
  input  logic [ADDR_W-1:0] ld_issue_addr,
  input  logic [ADDR_W-1:0] exu_rs1_addr,
  input  logic [ADDR_W-1:0] exu_rs2_addr,
  output logic              hazard,
  output logic              mprf_w_req,
  output logic [ADDR_W-1:0] mprf_rd_addr,
  output logic [XLEN-1:0]   mprf_rd_data
);

  localparam int CNT_W = (DBG_STARVE_MAX > 2) ? $clog2(DBG_STARVE_MAX) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DBG_STARVE_MAX - 1);

  type_scr1_dbg_fsm_e state, state_next;
  logic [CNT_W-1:0]   cnt, cnt_next;
  logic               rst_q;

  logic               pend_vld;
  logic [ADDR_W-1:0]  pend_addr;

  logic               buf_vld;
  logic [ADDR_W-1:0]  buf_addr;
  logic [XLEN-1:0]    buf_data;
  logic               buf_push;
  logic               buf_drain;

  type_scr1_wb_src_e  wb_src;
  type_scr1_wb_req_s  wb_sel;
  logic               force_dbg;
  logic               lsu_hs;

  scr1_pipe_wb_skid #(
    .ADDR_W (ADDR_W),
    .XLEN   (XLEN)
  ) i_skid (
    .clk       (clk),
    .rst       (rst),
    .push      (buf_push),
    .push_addr (lsu_rd_addr),
    .push_data (lsu_rd_data),
    .drain     (buf_drain),
    .buf_vld   (buf_vld),
    .buf_addr  (buf_addr),
    .buf_data  (buf_data)
  );

  // Handshake-style sources (LSU, debug) are held off for one cycle after reset
  always_ff @(posedge clk) begin
    rst_q <= rst;
  end

  always_comb begin
    force_dbg = (state == DBG_FORCE);
    lsu_w_rdy = ~buf_vld & ~force_dbg & ~rst & ~rst_q;
    lsu_hs    = lsu_w_vd & lsu_w_rdy;
    exu_stall = force_dbg & ~rst;

    wb_src = WB_NONE;
    if (rst)                     wb_src = WB_NONE;
    else if (force_dbg)          wb_src = WB_DBG;
    else if (exu_w_req)          wb_src = WB_EXU;
    else if (buf_vld)            wb_src = WB_BUF;
    else if (lsu_hs)             wb_src = WB_LSU;
    else if (dbg_w_req & ~rst_q) wb_src = WB_DBG;

    wb_sel = '0;
    case (wb_src)
      WB_EXU:  wb_sel = '{vd: 1'b1, addr: exu_rd_addr, data: exu_rd_data};
      WB_BUF:  wb_sel = '{vd: 1'b1, addr: buf_addr,    data: buf_data};
      WB_LSU:  wb_sel = '{vd: 1'b1, addr: lsu_rd_addr, data: lsu_rd_data};
      WB_DBG:  wb_sel = '{vd: 1'b1, addr: dbg_rd_addr, data: dbg_rd_data};
      default: wb_sel = '0;
    endcase

    mprf_w_req   = wb_sel.vd & (wb_sel.addr != '0);
    mprf_rd_addr = wb_sel.addr;
    mprf_rd_data = wb_sel.data;
    dbg_w_ack    = (wb_src == WB_DBG);
    buf_push     = lsu_hs & (wb_src != WB_LSU);
    buf_drain    = (wb_src == WB_BUF);
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      DBG_NORMAL: begin
        if (dbg_w_req & ~dbg_w_ack) begin
          if (cnt == CNT_LAST) state_next = DBG_FORCE;
          else                 cnt_next   = cnt + 1'b1;
        end else begin
          cnt_next = '0;
        end
      end
      DBG_FORCE: begin
        cnt_next   = '0;
        state_next = DBG_NORMAL;
      end
      default: begin
        cnt_next   = '0;
        state_next = DBG_NORMAL;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= DBG_NORMAL;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // A new issue overrides a same-cycle handshake clear
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_vld  <= 1'b0;
      pend_addr <= '0;
    end else if (ld_issue & (ld_issue_addr != '0)) begin
      pend_vld  <= 1'b1;
      pend_addr <= ld_issue_addr;
    end else if (lsu_hs) begin
      pend_vld  <= 1'b0;
    end
  end

  assign hazard = ~rst &
    ((pend_vld & (rd_match(exu_rs1_addr, pend_addr) | rd_match(exu_rs2_addr, pend_addr))) |
     (buf_vld  & (rd_match(exu_rs1_addr, buf_addr)  | rd_match(exu_rs2_addr, buf_addr))));

  ld_issue_single_outstanding: assert property (@(posedge clk) disable iff (rst)
    !(ld_issue && pend_vld && !lsu_hs));

endmodule

// File: tb/tb_scr1_pipe_mprf_wb_arb.sv
// Directed bench for the MPRF write-back arbiter with a per-cycle reference model.
module tb_scr1_pipe_mprf_wb_arb;

  localparam int DBG_STARVE_MAX = 8;

  typedef struct {
    logic        rst;
    logic        exu_w_req;
    logic [4:0]  exu_rd_addr;
    logic [31:0] exu_rd_data;
    logic        lsu_w_vd;
    logic [4:0]  lsu_rd_addr;
    logic [31:0] lsu_rd_data;
    logic        dbg_w_req;
    logic [4:0]  dbg_rd_addr;
    logic [31:0] dbg_rd_data;
    logic        ld_issue;
    logic [4:0]  ld_issue_addr;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
  } stim_t;

  logic        clk;
  logic        rst;
  logic        exu_w_req;
  logic [4:0]  exu_rd_addr;
  logic [31:0] exu_rd_data;
  logic        exu_stall;
  logic        lsu_w_vd;
  logic        lsu_w_rdy;
  logic [4:0]  lsu_rd_addr;
  logic [31:0] lsu_rd_data;
  logic        dbg_w_req;
  logic        dbg_w_ack;
  logic [4:0]  dbg_rd_addr;
  logic [31:0] dbg_rd_data;
  logic        ld_issue;
  logic [4:0]  ld_issue_addr;
  logic [4:0]  exu_rs1_addr;
  logic [4:0]  exu_rs2_addr;
  logic        hazard;
  logic        mprf_w_req;
  logic [4:0]  mprf_rd_addr;
  logic [31:0] mprf_rd_data;

  int checks   = 0;
  int failures = 0;

  // Reference model: pending loads as a queue of {addr,data}, denial run length
  logic [36:0] m_buf[$];
  bit          m_pend_vld = 0;
  logic [4:0]  m_pend_addr = '0;
  int          m_denied = 0;
  bit          m_force = 0;
  bit          m_rst_q = 0;

  logic        s_wreq, s_stall, s_rdy, s_ack, s_haz;
  logic [4:0]  s_addr;
  logic [31:0] s_data;

  scr1_pipe_mprf_wb_arb #(
    .ADDR_W         (5),
    .XLEN           (32),
    .DBG_STARVE_MAX (DBG_STARVE_MAX)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .exu_w_req     (exu_w_req),
    .exu_rd_addr   (exu_rd_addr),
    .exu_rd_data   (exu_rd_data),
    .exu_stall     (exu_stall),
    .lsu_w_vd      (lsu_w_vd),
    .lsu_w_rdy     (lsu_w_rdy),
    .lsu_rd_addr   (lsu_rd_addr),
    .lsu_rd_data   (lsu_rd_data),
    .dbg_w_req     (dbg_w_req),
    .dbg_w_ack     (dbg_w_ack),
    .dbg_rd_addr   (dbg_rd_addr),
    .dbg_rd_data   (dbg_rd_data),
    .ld_issue      (ld_issue),
    .ld_issue_addr (ld_issue_addr),
    .exu_rs1_addr  (exu_rs1_addr),
    .exu_rs2_addr  (exu_rs2_addr),
    .hazard        (hazard),
    .mprf_w_req    (mprf_w_req),
    .mprf_rd_addr  (mprf_rd_addr),
    .mprf_rd_data  (mprf_rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic stim_t idle();
    stim_t t;
    t = '{default: '0};
    return t;
  endfunction

  function automatic bit hit(input logic [4:0] a, input logic [4:0] r1, input logic [4:0] r2);
    return ((r1 != 0) && (r1 == a)) || ((r2 != 0) && (r2 == a));
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle, compare every output against the model, then advance the model
  task automatic applyStimulus(input stim_t s);
    int          src;
    logic [4:0]  a;
    logic [31:0] d;
    bit          rdy, hs, haz, buf_has;
    logic [41:0] exp_v, act_v;
    rst = s.rst; exu_w_req = s.exu_w_req; exu_rd_addr = s.exu_rd_addr;
    exu_rd_data = s.exu_rd_data; lsu_w_vd = s.lsu_w_vd; lsu_rd_addr = s.lsu_rd_addr;
    lsu_rd_data = s.lsu_rd_data; dbg_w_req = s.dbg_w_req; dbg_rd_addr = s.dbg_rd_addr;
    dbg_rd_data = s.dbg_rd_data; ld_issue = s.ld_issue; ld_issue_addr = s.ld_issue_addr;
    exu_rs1_addr = s.rs1; exu_rs2_addr = s.rs2;
    #1;
    buf_has = (m_buf.size() != 0);
    rdy = !s.rst && !m_rst_q && !m_force && !buf_has;
    hs  = s.lsu_w_vd && rdy;
    src = 0; a = '0; d = '0;
    if (s.rst)                         src = 0;
    else if (m_force)                  src = 4;
    else if (s.exu_w_req)              src = 1;
    else if (buf_has)                  src = 2;
    else if (hs)                       src = 3;
    else if (s.dbg_w_req && !m_rst_q)  src = 4;
    case (src)
      1: begin a = s.exu_rd_addr; d = s.exu_rd_data; end
      2: begin a = m_buf[0][36:32]; d = m_buf[0][31:0]; end
      3: begin a = s.lsu_rd_addr; d = s.lsu_rd_data; end
      4: begin a = s.dbg_rd_addr; d = s.dbg_rd_data; end
      default: begin a = '0; d = '0; end
    endcase
    haz = !s.rst && ((m_pend_vld && hit(m_pend_addr, s.rs1, s.rs2)) ||
                     (buf_has && hit(m_buf[0][36:32], s.rs1, s.rs2)));
    exp_v = {(src != 0) && (a != 0), a, d, !s.rst && m_force, rdy, src == 4, haz};
    act_v = {mprf_w_req, mprf_rd_addr, mprf_rd_data, exu_stall, lsu_w_rdy, dbg_w_ack, hazard};
    s_wreq = mprf_w_req; s_addr = mprf_rd_addr; s_data = mprf_rd_data;
    s_stall = exu_stall; s_rdy = lsu_w_rdy; s_ack = dbg_w_ack; s_haz = hazard;
    checkOutput("cycle", {22'd0, act_v}, {22'd0, exp_v});
    @(posedge clk);
    if (s.rst) begin
      m_buf.delete();
      m_pend_vld = 0;
      m_denied   = 0;
      m_force    = 0;
    end else begin
      if (src == 2) void'(m_buf.pop_front());
      if (hs && src != 3) m_buf.push_back({s.lsu_rd_addr, s.lsu_rd_data});
      if (s.ld_issue && s.ld_issue_addr != 0) begin
        m_pend_vld  = 1;
        m_pend_addr = s.ld_issue_addr;
      end else if (hs) begin
        m_pend_vld = 0;
      end
      if (m_force) begin
        m_force  = 0;
        m_denied = 0;
      end else if (s.dbg_w_req && src != 4) begin
        m_denied++;
        if (m_denied >= DBG_STARVE_MAX) m_force = 1;
      end else begin
        m_denied = 0;
      end
    end
    m_rst_q = s.rst;
    @(negedge clk);
  endtask

  initial begin
    stim_t s;
    int    ack_cycle;
    logic  stall_at_ack;
    logic [4:0] ack_addr;

    // Reset and the post-reset cycle
    s = idle(); s.rst = 1'b1;
    applyStimulus(s);
    applyStimulus(s);
    checkOutput("reset_rdy", 64'(s_rdy), 64'd0);
    s = idle();
    applyStimulus(s);
    checkOutput("post_reset_rdy", 64'(s_rdy), 64'd0);
    applyStimulus(s);
    checkOutput("idle_rdy", 64'(s_rdy), 64'd1);

    // Lone load, zero latency
    s = idle(); s.ld_issue = 1'b1; s.ld_issue_addr = 5'd5;
    applyStimulus(s);
    s = idle(); s.lsu_w_vd = 1'b1; s.lsu_rd_addr = 5'd5; s.lsu_rd_data = 32'hA5A5_0001; s.rs1 = 5'd5;
    applyStimulus(s);
    checkOutput("lone_ld_wreq", 64'(s_wreq), 64'd1);
    checkOutput("lone_ld_addr", 64'(s_addr), 64'd5);
    checkOutput("lone_ld_data", 64'(s_data), 64'hA5A5_0001);
    s = idle(); s.rs1 = 5'd5;
    applyStimulus(s);
    checkOutput("lone_ld_pend_clr", 64'(s_haz), 64'd0);

    // EXU/LSU collision: load goes through the skid buffer
    s = idle(); s.ld_issue = 1'b1; s.ld_issue_addr = 5'd7;
    applyStimulus(s);
    s = idle(); s.exu_w_req = 1'b1; s.exu_rd_addr = 5'd3; s.exu_rd_data = 32'h11;
    s.lsu_w_vd = 1'b1; s.lsu_rd_addr = 5'd7; s.lsu_rd_data = 32'h22; s.rs2 = 5'd7;
    applyStimulus(s);
    checkOutput("coll_c0_addr", 64'(s_addr), 64'd3);
    checkOutput("coll_c0_data", 64'(s_data), 64'h11);
    s = idle(); s.rs2 = 5'd7;
    applyStimulus(s);
    checkOutput("coll_c1_addr", 64'(s_addr), 64'd7);
    checkOutput("coll_c1_data", 64'(s_data), 64'h22);
    checkOutput("coll_c1_rdy", 64'(s_rdy), 64'd0);
    checkOutput("coll_c1_haz_buf", 64'(s_haz), 64'd1);
    s = idle();
    applyStimulus(s);
    checkOutput("coll_c2_rdy", 64'(s_rdy), 64'd1);

    // Read-after-load hazard
    s = idle(); s.ld_issue = 1'b1; s.ld_issue_addr = 5'd9;
    applyStimulus(s);
    s = idle(); s.rs1 = 5'd9;
    applyStimulus(s);
    checkOutput("haz_x9", 64'(s_haz), 64'd1);
    applyStimulus(s);
    s.lsu_w_vd = 1'b1; s.lsu_rd_addr = 5'd9; s.lsu_rd_data = 32'h99;
    applyStimulus(s);
    s = idle(); s.rs1 = 5'd9;
    applyStimulus(s);
    checkOutput("haz_x9_cleared", 64'(s_haz), 64'd0);
    s = idle(); s.ld_issue = 1'b1; s.ld_issue_addr = 5'd0;
    applyStimulus(s);
    s = idle(); s.rs1 = 5'd0; s.rs2 = 5'd9;
    applyStimulus(s);
    checkOutput("haz_x0_issue", 64'(s_haz), 64'd0);

    // LSU write to x0 completes without touching the MPRF
    s = idle(); s.lsu_w_vd = 1'b1; s.lsu_rd_addr = 5'd0; s.lsu_rd_data = 32'h55;
    applyStimulus(s);
    checkOutput("lsu_x0_wreq", 64'(s_wreq), 64'd0);
    checkOutput("lsu_x0_rdy", 64'(s_rdy), 64'd1);

    // Same-cycle handshake and new issue leave the new entry pending
    s = idle(); s.ld_issue = 1'b1; s.ld_issue_addr = 5'd11;
    applyStimulus(s);
    s = idle(); s.lsu_w_vd = 1'b1; s.lsu_rd_addr = 5'd11; s.lsu_rd_data = 32'hB;
    s.ld_issue = 1'b1; s.ld_issue_addr = 5'd12;
    applyStimulus(s);
    s = idle(); s.rs1 = 5'd12;
    applyStimulus(s);
    checkOutput("haz_reissue", 64'(s_haz), 64'd1);
    s = idle(); s.lsu_w_vd = 1'b1; s.lsu_rd_addr = 5'd12; s.lsu_rd_data = 32'hC;
    applyStimulus(s);

    // Debug starvation under continuous EXU traffic
    ack_cycle = -1; stall_at_ack = 1'b0; ack_addr = '0;
    for (int c = 0; c < 20 && ack_cycle < 0; c++) begin
      s = idle(); s.exu_w_req = 1'b1; s.exu_rd_addr = 5'(1 + c % 8); s.exu_rd_data = 32'h1000 + c;
      s.dbg_w_req = 1'b1; s.dbg_rd_addr = 5'd4; s.dbg_rd_data = 32'hDB90_0004;
      applyStimulus(s);
      if (s_ack === 1'b1) begin
        ack_cycle = c; stall_at_ack = s_stall; ack_addr = s_addr;
      end
    end
    checkOutput("starve_ack_cycle", 64'(ack_cycle), 64'd8);
    checkOutput("starve_stall", 64'(stall_at_ack), 64'd1);
    checkOutput("starve_addr", 64'(ack_addr), 64'd4);
    s = idle(); s.exu_w_req = 1'b1; s.exu_rd_addr = 5'd2; s.exu_rd_data = 32'h2;
    applyStimulus(s);
    checkOutput("starve_back_normal", 64'(s_stall), 64'd0);

    // Uncontended debug write, then debug losing to LSU
    s = idle(); s.dbg_w_req = 1'b1; s.dbg_rd_addr = 5'd8; s.dbg_rd_data = 32'h8888;
    applyStimulus(s);
    checkOutput("dbg_lone_ack", 64'(s_ack), 64'd1);
    s = idle();
    applyStimulus(s);
    s = idle(); s.lsu_w_vd = 1'b1; s.lsu_rd_addr = 5'd13; s.lsu_rd_data = 32'hD;
    s.dbg_w_req = 1'b1; s.dbg_rd_addr = 5'd14; s.dbg_rd_data = 32'hE;
    applyStimulus(s);
    checkOutput("dbg_vs_lsu_ack", 64'(s_ack), 64'd0);
    s = idle(); s.dbg_w_req = 1'b1; s.dbg_rd_addr = 5'd14; s.dbg_rd_data = 32'hE;
    applyStimulus(s);
    checkOutput("dbg_after_lsu_ack", 64'(s_ack), 64'd1);
    s = idle();
    applyStimulus(s);

    // EXU write to x0, and an x0 load drained from the buffer
    s = idle(); s.exu_w_req = 1'b1; s.exu_rd_addr = 5'd0; s.exu_rd_data = 32'hFF;
    applyStimulus(s);
    checkOutput("exu_x0_wreq", 64'(s_wreq), 64'd0);
    s.lsu_w_vd = 1'b1; s.lsu_rd_addr = 5'd0; s.lsu_rd_data = 32'h77; s.exu_rd_addr = 5'd1;
    applyStimulus(s);
    s = idle();
    applyStimulus(s);
    checkOutput("buf_x0_wreq", 64'(s_wreq), 64'd0);

    // Reset while the buffer holds a load
    s = idle(); s.exu_w_req = 1'b1; s.exu_rd_addr = 5'd2; s.exu_rd_data = 32'h2;
    s.lsu_w_vd = 1'b1; s.lsu_rd_addr = 5'd6; s.lsu_rd_data = 32'h66;
    applyStimulus(s);
    s = idle(); s.rst = 1'b1;
    applyStimulus(s);
    checkOutput("rst_buf_wreq", 64'(s_wreq), 64'd0);
    checkOutput("rst_buf_rdy", 64'(s_rdy), 64'd0);
    s = idle();
    applyStimulus(s);
    checkOutput("rst_buf_flushed", 64'(s_wreq), 64'd0);
    applyStimulus(s);
    checkOutput("rst_buf_rdy_back", 64'(s_rdy), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
